bcd_countdown_ctrl: RTL and testbench

Sequencing controller for a cascaded BCD decade-counter chain used as a programmable countdown timer. It loads a BCD preset and decrements it at a prescaled tick rate. It supports start, pause and resume, and issues a one-cycle done pulse at zero. It sits between command logic and the decade digit datapath, replacing hand-wired clear gating with a synchronous, single-clock design.

---
 rtl/bcd_countdown_ctrl.sv | 116 +++++++++++
 tb/tb_bcd_countdown_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_countdown_ctrl.sv
// rtl/bcd_countdown_ctrl.sv - prescaled BCD countdown timer controller with load/start/pause/resume and done pulse
module bcd_countdown_ctrl #(
  parameter int DIGITS   = 2,
  parameter int TICK_DIV = 4
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   preset,
  input  logic                  start,
  input  logic                  pause,
  output logic [4*DIGITS-1:0]   cnt,
  output logic [1:0]            state,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int W = 4 * DIGITS;
  localparam logic [7:0] TICK_LAST = 8'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    HOLD    = 2'b10,
    EXPIRED = 2'b11
  } state_t;

  state_t       st;
  logic [7:0]   pre;
  logic         preset_ok;
  logic [W-1:0] cnt_dec;

  always_comb begin
    preset_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (preset[4*i +: 4] > 4'd9) preset_ok = 1'b0;
    end
  end

  // Ripple-borrow BCD decrement: a zero digit wraps to 9 and passes the borrow on.
  always_comb begin
    logic borrow;
    cnt_dec = cnt;
    borrow  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (cnt[4*i +: 4] == 4'd0) begin
          cnt_dec[4*i +: 4] = 4'd9;
        end else begin
          cnt_dec[4*i +: 4] = cnt[4*i +: 4] - 4'd1;
          borrow            = 1'b0;
        end
      end
    end
  end

  assign state = st;
  assign busy  = (st == RUN) || (st == HOLD);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      st   <= IDLE;
      cnt  <= '0;
      pre  <= 8'd0;
      done <= 1'b0;
      err  <= 1'b0;
    end else begin
      done <= 1'b0;
      // load outranks start in every state where it is honoured
      if (load && st != RUN) begin
        if (preset_ok) begin
          cnt <= preset;
          err <= 1'b0;
          pre <= 8'd0;
          st  <= IDLE;
        end else begin
          err <= 1'b1;
        end
      end else begin
        case (st)
          IDLE: begin
            if (start) begin
              if (cnt != '0) begin
                st  <= RUN;
                pre <= 8'd0;
              end else begin
                st   <= EXPIRED;
                done <= 1'b1;
              end
            end
          end
          RUN: begin
            if (pause) begin
              st <= HOLD;
            end else if (pre == TICK_LAST) begin
              pre <= 8'd0;
              cnt <= cnt_dec;
              if (cnt_dec == '0) begin
                st   <= EXPIRED;
                done <= 1'b1;
              end
            end else begin
              pre <= pre + 8'd1;
            end
          end
          HOLD: begin
            if (start) st <= RUN;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bcd_countdown_ctrl.sv
// tb/tb_bcd_countdown_ctrl.sv - vector table, corner sequences and random run against a decimal reference model
module tb_bcd_countdown_ctrl;

  localparam int DG = 2;
  localparam int TD = 4;

  logic       clk;
  logic       clr;
  logic       load;
  logic [7:0] preset;
  logic       start;
  logic       pause;
  logic [7:0] cnt;
  logic [1:0] state;
  logic       busy;
  logic       done;
  logic       err;

  int total = 0;
  int bad   = 0;

  bcd_countdown_ctrl #(.DIGITS(DG), .TICK_DIV(TD)) dut (
    .clk(clk), .clr(clr), .load(load), .preset(preset), .start(start),
    .pause(pause), .cnt(cnt), .state(state), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: count held as a plain decimal integer, time as elapsed cycles in the current tick.
  int m_val, m_st, m_ph, m_done, m_err;

  function automatic int bcd_to_int(input logic [7:0] v);
    return int'(v[3:0]) + 10 * int'(v[7:4]);
  endfunction

  function automatic logic [7:0] int_to_bcd(input int v);
    logic [7:0] r;
    r[3:0] = 4'(v % 10);
    r[7:4] = 4'((v / 10) % 10);
    return r;
  endfunction

  task automatic model_reset();
    m_val = 0; m_st = 0; m_ph = 0; m_done = 0; m_err = 0;
  endtask

  task automatic model_step(input logic l, input logic [7:0] p, input logic s, input logic pa);
    m_done = 0;
    if (l && m_st != 1) begin
      if (p[3:0] <= 4'd9 && p[7:4] <= 4'd9) begin
        m_val = bcd_to_int(p); m_err = 0; m_ph = 0; m_st = 0;
      end else begin
        m_err = 1;
      end
    end else if (m_st == 0) begin
      if (s) begin
        if (m_val > 0) begin m_st = 1; m_ph = 0; end
        else begin m_st = 3; m_done = 1; end
      end
    end else if (m_st == 1) begin
      if (pa) m_st = 2;
      else begin
        m_ph++;
        if (m_ph == TD) begin
          m_ph = 0;
          m_val--;
          if (m_val == 0) begin m_st = 3; m_done = 1; end
        end
      end
    end else if (m_st == 2) begin
      if (s) m_st = 1;
    end
  endtask

  task automatic apply(input logic l, input logic [7:0] p, input logic s, input logic pa);
    load = l; preset = p; start = s; pause = pa;
    @(posedge clk);
    #1;
    load = 1'b0; start = 1'b0; pause = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr = 1'b0;
    #2;
    clr = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       ld;
    logic [7:0] pr;
    logic       st;
    logic       pa;
    logic [7:0] e_cnt;
    logic [1:0] e_state;
    logic       e_done;
    logic       e_err;
  } vec_t;

  vec_t vecs[19];
  int   first_done, n_done;

  initial begin
    vecs[0]  = '{1'b1, 8'h1A, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b1};
    vecs[1]  = '{1'b1, 8'h09, 1'b0, 1'b0, 8'h09, 2'b00, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 2'b11, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 2'b11, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 2'b11, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 2'b11, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 8'h99, 1'b1, 1'b0, 8'h99, 2'b00, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h99, 2'b00, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 8'h9F, 1'b0, 1'b0, 8'h99, 2'b00, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 8'h02, 1'b0, 1'b0, 8'h02, 2'b00, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h02, 2'b01, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h02, 2'b10, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 8'h03, 1'b1, 1'b0, 8'h03, 2'b00, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h03, 2'b01, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h03, 2'b01, 1'b0, 1'b0};
    vecs[16] = '{1'b1, 8'h40, 1'b0, 1'b0, 8'h03, 2'b01, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h03, 2'b01, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h02, 2'b01, 1'b0, 1'b0};

    clr = 1'b0; load = 1'b0; preset = 8'h00; start = 1'b0; pause = 1'b0;
    #3;
    chk("reset_cnt",   32'(cnt),   32'h00);
    chk("reset_state", 32'(state), 32'h0);
    chk("reset_busy",  32'(busy),  32'h0);
    chk("reset_done",  32'(done),  32'h0);
    chk("reset_err",   32'(err),   32'h0);
    #9;
    clr = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 19; i++) begin
      apply(vecs[i].ld, vecs[i].pr, vecs[i].st, vecs[i].pa);
      chk($sformatf("vec%0d_cnt", i),   32'(cnt),   32'(vecs[i].e_cnt));
      chk($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].e_state));
      chk($sformatf("vec%0d_done", i),  32'(done),  32'(vecs[i].e_done));
      chk($sformatf("vec%0d_err", i),   32'(err),   32'(vecs[i].e_err));
      chk($sformatf("vec%0d_busy", i),  32'(busy),
          32'(vecs[i].e_state == 2'b01 || vecs[i].e_state == 2'b10));
    end

    // Full countdown from 12: one done pulse, 48 edges after the start edge.
    do_reset();
    apply(1'b1, 8'h12, 1'b0, 1'b0);
    apply(1'b0, 8'h00, 1'b1, 1'b0);
    first_done = -1; n_done = 0;
    for (int k = 1; k <= 60; k++) begin
      apply(1'b0, 8'h00, 1'b0, 1'b0);
      if (done) begin n_done++; if (first_done < 0) first_done = k; end
      if (k == 4)  chk("cd_cnt_k4",  32'(cnt), 32'h11);
      if (k == 8)  chk("cd_cnt_k8",  32'(cnt), 32'h10);
      if (k == 11) chk("cd_cnt_k11", 32'(cnt), 32'h10);
      if (k == 12) chk("cd_cnt_k12", 32'(cnt), 32'h09);
      if (k == 48) begin
        chk("cd_cnt_k48",   32'(cnt),   32'h00);
        chk("cd_state_k48", 32'(state), 32'h3);
      end
    end
    chk("cd_done_edge",  32'(first_done), 32'd48);
    chk("cd_done_count", 32'(n_done),     32'd1);

    // Pause on prescaler=2 for 7 cycles, then resume: expiry moves from 20 to 28.
    apply(1'b1, 8'h05, 1'b0, 1'b0);
    apply(1'b0, 8'h00, 1'b1, 1'b0);
    first_done = -1; n_done = 0;
    for (int k = 1; k <= 40; k++) begin
      apply(1'b0, 8'h00, k == 10, k >= 3 && k <= 9);
      if (done) begin n_done++; if (first_done < 0) first_done = k; end
      if (k == 9) begin
        chk("pr_hold_state", 32'(state), 32'h2);
        chk("pr_hold_cnt",   32'(cnt),   32'h05);
        chk("pr_hold_busy",  32'(busy),  32'h1);
      end
      if (k == 11) chk("pr_cnt_k11", 32'(cnt), 32'h05);
      if (k == 12) chk("pr_cnt_k12", 32'(cnt), 32'h04);
    end
    chk("pr_done_edge",  32'(first_done), 32'd28);
    chk("pr_done_count", 32'(n_done),     32'd1);

    // Asynchronous reset in the middle of a run.
    apply(1'b1, 8'h37, 1'b0, 1'b0);
    apply(1'b0, 8'h00, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) apply(1'b0, 8'h00, 1'b0, 1'b0);
    chk("mr_busy_before", 32'(busy), 32'h1);
    chk("mr_cnt_before",  32'(cnt),  32'h35);
    #2;
    clr = 1'b0;
    #1;
    chk("mr_cnt",   32'(cnt),   32'h00);
    chk("mr_state", 32'(state), 32'h0);
    chk("mr_busy",  32'(busy),  32'h0);
    chk("mr_done",  32'(done),  32'h0);
    #2;
    clr = 1'b1;
    @(posedge clk);
    #1;

    // Random commands against the reference model.
    do_reset();
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      logic       l, s, pa;
      logic [7:0] p;
      l  = ($urandom_range(0, 19) == 0);
      s  = ($urandom_range(0, 3) == 0);
      pa = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 1) == 0) p = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      else p = 8'($urandom);
      apply(l, p, s, pa);
      model_step(l, p, s, pa);
      chk("rnd_cnt",   32'(cnt),   32'(int_to_bcd(m_val)));
      chk("rnd_state", 32'(state), 32'(m_st));
      chk("rnd_busy",  32'(busy),  32'(m_st == 1 || m_st == 2));
      chk("rnd_done",  32'(done),  32'(m_done));
      chk("rnd_err",   32'(err),   32'(m_err));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
